// File: rtl/dnn2ami_arb_pkg.sv
// Shared owner-state encoding and parameter defaults for the DNN-to-AMI request arbiter.
`ifndef AMI_REQUEST_BUS_WIDTH
`include "AMITypes.sv"
`endif
package dnn2ami_arb_pkg;

   localparam int AMI_REQ_W              = `AMI_REQUEST_BUS_WIDTH;
   localparam int MAX_RD_OUTSTANDING_DEF = 16;
   localparam int WR_BURST_MAX_DEF       = 8;
   localparam int CNT_W_DEF              = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } owner_e;

endpackage

// File: rtl/dnn2ami_req_arbiter_if.sv
// Request/grant bundle between the read/write request paths, the arbiter and the AMI port.
interface dnn2ami_req_arbiter_if
   import dnn2ami_arb_pkg::*;
#(
   parameter int W = AMI_REQ_W
);
   logic         rd_reqValid;
   logic [W-1:0] rd_reqOut;
   logic         rd_grant;
   logic         wr_reqValid;
   logic [W-1:0] wr_reqOut;
   logic         wr_grant;
   logic         reqValid;
   logic [W-1:0] reqOut;
   logic         reqOut_grant;
   logic         rd_rsp_valid;

   // Arbiter side
   modport slave (
      input  rd_reqValid, rd_reqOut, wr_reqValid, wr_reqOut, reqOut_grant, rd_rsp_valid,
      output rd_grant, wr_grant, reqValid, reqOut
   );

   // Request sources and memory port side
   modport master (
      output rd_reqValid, rd_reqOut, wr_reqValid, wr_reqOut, reqOut_grant, rd_rsp_valid,
      input  rd_grant, wr_grant, reqValid, reqOut
   );
endinterface

// File: rtl/AMITypes.sv
// AMI request-bus layout shared by every block that drives or sinks AMI requests.
// Field macros are listed LSB-first; the total width is their sum.
`ifndef AMITYPES_SV
`define AMITYPES_SV
`define AMI_REQ_ADDR_W        32
`define AMI_REQ_DATA_W        24
`define AMI_REQ_SIZE_W        6
`define AMI_REQ_ISWRITE_W     1
`define AMI_REQ_VALID_W       1
`define AMI_REQUEST_BUS_WIDTH (`AMI_REQ_ADDR_W + `AMI_REQ_DATA_W + `AMI_REQ_SIZE_W + `AMI_REQ_ISWRITE_W + `AMI_REQ_VALID_W)
`endif

// File: rtl/dnn2ami_credit_counter.sv
// Outstanding-read credit counter with a sticky underflow flag; updates one cycle after inc/dec.
// Saturates at both ends rather than wrapping; has_credit is combinational from the count.
module dnn2ami_credit_counter #(
   parameter int CNT_W = 5,
   parameter int MAX   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             has_credit,
   output logic             err_underflow
);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

   assign has_credit = (cnt < MAX_C);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt           <= '0;
         err_underflow <= 1'b0;
      end else begin
         if (inc && !dec && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
         end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
         // A response with nothing outstanding is a protocol error upstream.
         if (dec && (cnt == '0)) begin
            err_underflow <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/dnn2ami_req_arbiter.sv
// Arbitrates read and write request paths onto one AMI request port; grants are combinational,
// one idle cycle of arbitration from IDLE; reads are credit-limited, writes burst-limited when reads wait.
module dnn2ami_req_arbiter
   import dnn2ami_arb_pkg::*;
#(
   parameter int MAX_RD_OUTSTANDING = MAX_RD_OUTSTANDING_DEF,
   parameter int WR_BURST_MAX       = WR_BURST_MAX_DEF,
   parameter int CNT_W              = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   dnn2ami_req_arbiter_if.slave bus,
   output logic [CNT_W-1:0]     rd_outstanding,
   output logic                 err_underflow
);
   localparam int              BW          = $clog2(WR_BURST_MAX + 1);
   localparam logic [BW-1:0]   BURST_LAST  = BW'(WR_BURST_MAX - 1);
   localparam logic [BW-1:0]   BURST_CAP   = BW'(WR_BURST_MAX);

   owner_e              state;
   owner_e              last_served;
   logic [BW-1:0]       burst_cnt;
   logic                has_credit;
   logic                rd_eligible;
   logic                req_vld;
   logic [AMI_REQ_W-1:0] req_dat;
   logic                rd_gnt;
   logic                wr_gnt;

   dnn2ami_credit_counter #(
      .CNT_W (CNT_W),
      .MAX   (MAX_RD_OUTSTANDING)
   ) u_credit (
      .clk           (clk),
      .rst           (rst),
      .inc           (rd_gnt),
      .dec           (bus.rd_rsp_valid),
      .cnt           (rd_outstanding),
      .has_credit    (has_credit),
      .err_underflow (err_underflow)
   );

   assign rd_eligible = bus.rd_reqValid && has_credit;

   // Request is masked while reset is held so nothing is offered before the FSM is known.
   always_comb begin
      req_vld = 1'b0;
      req_dat = '0;
      case (state)
         ST_RD: begin
            req_vld = rd_eligible;
            req_dat = bus.rd_reqOut;
         end
         ST_WR: begin
            req_vld = bus.wr_reqValid;
            req_dat = bus.wr_reqOut;
         end
         default: begin
            req_vld = 1'b0;
            req_dat = '0;
         end
      endcase
      if (rst) begin
         req_vld = 1'b0;
      end
   end

   assign rd_gnt       = (state == ST_RD) && req_vld && bus.reqOut_grant;
   assign wr_gnt       = (state == ST_WR) && req_vld && bus.reqOut_grant;
   assign bus.reqValid = req_vld;
   assign bus.reqOut   = req_dat;
   assign bus.rd_grant = rd_gnt;
   assign bus.wr_grant = wr_gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         last_served <= ST_RD;
         burst_cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               burst_cnt <= '0;
               if (bus.wr_reqValid && (!rd_eligible || (last_served == ST_RD))) begin
                  state <= ST_WR;
               end else if (rd_eligible) begin
                  state <= ST_RD;
               end
            end
            ST_RD: begin
               if ((rd_gnt && bus.wr_reqValid) || !rd_eligible) begin
                  state       <= bus.wr_reqValid ? ST_WR : ST_IDLE;
                  last_served <= ST_RD;
                  burst_cnt   <= '0;
               end
            end
            ST_WR: begin
               // The burst limit only bites when a read is actually waiting.
               if (wr_gnt && (burst_cnt >= BURST_LAST) && rd_eligible) begin
                  state       <= ST_RD;
                  last_served <= ST_WR;
               end else if (!bus.wr_reqValid) begin
                  state       <= rd_eligible ? ST_RD : ST_IDLE;
                  last_served <= ST_WR;
               end else if (wr_gnt && (burst_cnt != BURST_CAP)) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dnn2ami_req_arbiter.sv
// Directed-vector bench for dnn2ami_req_arbiter with hand-computed expectations.
module tb_dnn2ami_req_arbiter;
   import dnn2ami_arb_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] rd_outstanding;
   logic       err_underflow;

   int vecs = 0;
   int errs = 0;
   int nr, nw, nstable;
   logic last_rd;
   logic [27:0] rdm, wrm;

   localparam logic [63:0] RD_PAY = 64'hA5A5_0000_1111_0001;
   localparam logic [63:0] WR_PAY = 64'h5A5A_0000_2222_0002;

   dnn2ami_req_arbiter_if #(.W(AMI_REQ_W)) bus ();

   dnn2ami_req_arbiter #(
      .MAX_RD_OUTSTANDING (16),
      .WR_BURST_MAX       (8),
      .CNT_W              (5)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus.slave),
      .rd_outstanding (rd_outstanding),
      .err_underflow  (err_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst              = 1'b1;
      bus.rd_reqValid  = 1'b0;
      bus.wr_reqValid  = 1'b0;
      bus.reqOut_grant = 1'b0;
      bus.rd_rsp_valid = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      bus.rd_reqOut    = AMI_REQ_W'(RD_PAY);
      bus.wr_reqOut    = AMI_REQ_W'(WR_PAY);
      bus.rd_reqValid  = 1'b1;
      bus.wr_reqValid  = 1'b1;
      bus.reqOut_grant = 1'b1;
      bus.rd_rsp_valid = 1'b0;

      // Reset state with both sources requesting
      cyc();
      cyc();
      #3;
      chk("rst_reqValid", 64'(bus.reqValid), 64'd0);
      chk("rst_rd_grant", 64'(bus.rd_grant), 64'd0);
      chk("rst_wr_grant", 64'(bus.wr_grant), 64'd0);
      chk("rst_count", 64'(rd_outstanding), 64'd0);
      chk("rst_err", 64'(err_underflow), 64'd0);
      cyc();
      rst = 1'b0;
      #3;
      chk("post_rst_reqValid", 64'(bus.reqValid), 64'd0);
      cyc();
      #3;
      chk("first_owner_wr", 64'(bus.wr_grant), 64'd1);
      chk("first_owner_not_rd", 64'(bus.rd_grant), 64'd0);
      cyc();

      // Reads only: credit limit of 16
      do_reset();
      bus.rd_reqValid  = 1'b1;
      bus.reqOut_grant = 1'b1;
      nr = 0;
      repeat (20) begin
         #3;
         nr += int'(bus.rd_grant);
         cyc();
      end
      #3;
      chk("rd_credit_grants", 64'(nr), 64'd16);
      chk("rd_credit_reqValid", 64'(bus.reqValid), 64'd0);
      chk("rd_credit_count", 64'(rd_outstanding), 64'd16);
      cyc();
      bus.rd_rsp_valid = 1'b1;
      #3;
      cyc();
      bus.rd_rsp_valid = 1'b0;
      nr = 0;
      repeat (8) begin
         #3;
         nr += int'(bus.rd_grant);
         cyc();
      end
      #3;
      chk("rd_refill_grants", 64'(nr), 64'd1);
      chk("rd_refill_count", 64'(rd_outstanding), 64'd16);
      cyc();

      // Writes only: 20 beats, no burst limit without waiting reads
      do_reset();
      bus.wr_reqValid  = 1'b1;
      bus.reqOut_grant = 1'b1;
      nr = 0;
      nw = 0;
      repeat (21) begin
         #3;
         nw += int'(bus.wr_grant);
         nr += int'(bus.rd_grant);
         cyc();
      end
      bus.wr_reqValid = 1'b0;
      #3;
      chk("wr_only_grants", 64'(nw), 64'd20);
      chk("wr_only_no_rd", 64'(nr), 64'd0);
      chk("wr_only_drop_vld", 64'(bus.reqValid), 64'd0);
      cyc();

      // Both valid, prompt responses: 8 writes then 1 read, repeating
      do_reset();
      bus.rd_reqValid  = 1'b1;
      bus.wr_reqValid  = 1'b1;
      bus.reqOut_grant = 1'b1;
      last_rd = 1'b0;
      rdm = '0;
      wrm = '0;
      for (int i = 0; i < 28; i++) begin
         bus.rd_rsp_valid = last_rd;
         #3;
         rdm[i]  = bus.rd_grant;
         wrm[i]  = bus.wr_grant;
         last_rd = bus.rd_grant;
         cyc();
      end
      chk("mix_rd_pattern", 64'(rdm), 64'h000_0000_0804_0200);
      chk("mix_wr_pattern", 64'(wrm), 64'h000_0000_07FB_FDFE);

      // Port stalled with both valid: owner and payload must hold
      bus.rd_rsp_valid = 1'b0;
      bus.reqOut_grant = 1'b0;
      nr = 0;
      nw = 0;
      nstable = 0;
      repeat (10) begin
         #3;
         nr += int'(bus.rd_grant);
         nw += int'(bus.wr_grant);
         if (bus.reqValid && (64'(bus.reqOut) == WR_PAY)) nstable++;
         cyc();
      end
      bus.reqOut_grant = 1'b1;
      #3;
      chk("stall_no_rd", 64'(nr), 64'd0);
      chk("stall_no_wr", 64'(nw), 64'd0);
      chk("stall_reqOut_stable", 64'(nstable), 64'd10);
      chk("stall_release_wr", 64'(bus.wr_grant), 64'd1);
      chk("stall_count", 64'(rd_outstanding), 64'd1);
      cyc();

      // Simultaneous grant and response, then underflow
      do_reset();
      bus.rd_reqValid  = 1'b1;
      bus.reqOut_grant = 1'b1;
      nr = 0;
      for (int i = 0; i < 7; i++) begin
         bus.rd_rsp_valid = (i == 6);
         #3;
         nr += int'(bus.rd_grant);
         cyc();
      end
      bus.rd_rsp_valid = 1'b0;
      bus.rd_reqValid  = 1'b0;
      #3;
      chk("same_cycle_grants", 64'(nr), 64'd6);
      chk("same_cycle_count", 64'(rd_outstanding), 64'd5);
      cyc();
      repeat (5) begin
         bus.rd_rsp_valid = 1'b1;
         #3;
         cyc();
      end
      bus.rd_rsp_valid = 1'b0;
      #3;
      chk("drain_count", 64'(rd_outstanding), 64'd0);
      chk("drain_no_err", 64'(err_underflow), 64'd0);
      cyc();
      bus.rd_rsp_valid = 1'b1;
      #3;
      cyc();
      bus.rd_rsp_valid = 1'b0;
      #3;
      chk("underflow_err", 64'(err_underflow), 64'd1);
      chk("underflow_count", 64'(rd_outstanding), 64'd0);
      cyc();
      #3;
      chk("underflow_sticky", 64'(err_underflow), 64'd1);
      cyc();

      // Reset in the middle of a write burst with reads in flight
      do_reset();
      bus.rd_reqValid  = 1'b1;
      bus.reqOut_grant = 1'b1;
      repeat (4) begin
         #3;
         cyc();
      end
      bus.rd_reqValid = 1'b0;
      bus.wr_reqValid = 1'b1;
      nw = 0;
      repeat (5) begin
         #3;
         nw += int'(bus.wr_grant);
         cyc();
      end
      rst = 1'b1;
      #3;
      chk("midburst_beats", 64'(nw), 64'd4);
      chk("midburst_count", 64'(rd_outstanding), 64'd3);
      chk("midburst_rst_no_wr", 64'(bus.wr_grant), 64'd0);
      cyc();
      rst = 1'b0;
      #3;
      chk("after_rst_reqValid", 64'(bus.reqValid), 64'd0);
      chk("after_rst_no_wr", 64'(bus.wr_grant), 64'd0);
      chk("after_rst_count", 64'(rd_outstanding), 64'd0);
      cyc();
      #3;
      chk("after_rst_resume_wr", 64'(bus.wr_grant), 64'd1);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
